// File: rtl/mux_scan_sequencer.sv
// Walks the enabled channels of a 4:1 mux, holding each address SETTLE_CYCLES edges before sampling.
// Frame ready k*SETTLE_CYCLES edges after start; unaccepted words are overwritten with sticky overrun.
module mux_scan_sequencer #(
   parameter int SETTLE_CYCLES = 2,
   parameter bit CONTINUOUS    = 1'b0
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic       i_stop,
   input  logic [3:0] i_chan_mask,
   input  logic       i_mux_out,
   output logic       o_address0,
   output logic       o_address1,
   output logic [3:0] o_word,
   output logic       o_word_valid,
   input  logic       i_word_ready,
   output logic       o_busy,
   output logic       o_overrun
);
   localparam int            CW   = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] LOAD = CW'(SETTLE_CYCLES);

   typedef enum logic {IDLE, SETTLE} state_t;

   state_t        r_state;
   logic [3:0]    r_mask_q;
   logic [3:0]    r_capture;
   logic [3:0]    r_word;
   logic [1:0]    r_ch;
   logic [CW-1:0] r_cnt;
   logic          r_word_valid;
   logic          r_overrun;

   logic          w_busy;
   logic          w_accept;
   logic          w_sample;
   logic          w_done;
   logic          w_has_next;
   logic [1:0]    w_next_ch;
   logic [3:0]    w_cap_merged;

   function automatic logic [1:0] f_lowest(input logic [3:0] m);
      logic [1:0] ch;
      ch = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) ch = 2'(i);
      end
      return ch;
   endfunction

   assign w_busy   = (r_state != IDLE) | r_word_valid;
   assign w_accept = (r_state == IDLE) & i_start & ~i_stop & ~w_busy & (|i_chan_mask);
   assign w_sample = (r_state == SETTLE) & ~i_stop & (r_cnt == CW'(1));
   assign w_done   = w_sample & ~w_has_next;

   // Downward scan leaves the lowest enabled channel above the current one.
   always_comb begin
      w_has_next = 1'b0;
      w_next_ch  = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (r_mask_q[i] && (2'(i) > r_ch)) begin
            w_has_next = 1'b1;
            w_next_ch  = 2'(i);
         end
      end
   end

   always_comb begin
      w_cap_merged       = r_capture;
      w_cap_merged[r_ch] = i_mux_out;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= IDLE;
         r_mask_q     <= 4'd0;
         r_capture    <= 4'd0;
         r_word       <= 4'd0;
         r_ch         <= 2'd0;
         r_cnt        <= '0;
         r_word_valid <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         // A completing frame takes priority over consumption so valid stays high.
         if (w_done) begin
            r_word       <= w_cap_merged;
            r_word_valid <= 1'b1;
            if (r_word_valid && !i_word_ready) r_overrun <= 1'b1;
         end else if (r_word_valid && i_word_ready) begin
            r_word_valid <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_mask_q  <= i_chan_mask;
                  r_capture <= 4'd0;
                  r_ch      <= f_lowest(i_chan_mask);
                  r_cnt     <= LOAD;
                  r_state   <= SETTLE;
               end
            end
            SETTLE: begin
               if (i_stop) begin
                  r_state   <= IDLE;
                  r_capture <= 4'd0;
               end else if (w_sample) begin
                  if (w_has_next) begin
                     r_capture <= w_cap_merged;
                     r_ch      <= w_next_ch;
                     r_cnt     <= LOAD;
                  end else if (CONTINUOUS) begin
                     r_capture <= 4'd0;
                     r_ch      <= f_lowest(r_mask_q);
                     r_cnt     <= LOAD;
                  end else begin
                     r_capture <= w_cap_merged;
                     r_cnt     <= '0;
                     r_state   <= IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_address0   = r_ch[0];
   assign o_address1   = r_ch[1];
   assign o_word       = r_word;
   assign o_word_valid = r_word_valid;
   assign o_busy       = w_busy;
   assign o_overrun    = r_overrun;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench: single-shot instance (SETTLE_CYCLES=2) and continuous instance (SETTLE_CYCLES=1).
module tb_mux_scan_sequencer;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int n_assert;
   int n_fail;

   logic       a_start, a_stop, a_ready, a_mux;
   logic [3:0] a_mask, a_in, a_word;
   logic       a_addr0, a_addr1, a_valid, a_busy, a_ovr;
   logic [1:0] a_addr;

   logic       b_start, b_stop, b_ready, b_mux;
   logic [3:0] b_mask, b_in, b_word;
   logic       b_addr0, b_addr1, b_valid, b_busy, b_ovr;
   logic [1:0] b_addr;

   assign a_addr = {a_addr1, a_addr0};
   assign b_addr = {b_addr1, b_addr0};
   assign a_mux  = a_in[a_addr];
   assign b_mux  = b_in[b_addr];

   mux_scan_sequencer #(.SETTLE_CYCLES(2), .CONTINUOUS(1'b0)) u_single (
      .i_clk(clk), .i_reset(reset), .i_start(a_start), .i_stop(a_stop),
      .i_chan_mask(a_mask), .i_mux_out(a_mux), .o_address0(a_addr0), .o_address1(a_addr1),
      .o_word(a_word), .o_word_valid(a_valid), .i_word_ready(a_ready),
      .o_busy(a_busy), .o_overrun(a_ovr)
   );

   mux_scan_sequencer #(.SETTLE_CYCLES(1), .CONTINUOUS(1'b1)) u_cont (
      .i_clk(clk), .i_reset(reset), .i_start(b_start), .i_stop(b_stop),
      .i_chan_mask(b_mask), .i_mux_out(b_mux), .o_address0(b_addr0), .o_address1(b_addr1),
      .o_word(b_word), .o_word_valid(b_valid), .i_word_ready(b_ready),
      .o_busy(b_busy), .o_overrun(b_ovr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      reset    = 1'b1;
      a_start = 1'b0; a_stop = 1'b0; a_ready = 1'b0; a_mask = 4'd0; a_in = 4'd0;
      b_start = 1'b0; b_stop = 1'b0; b_ready = 1'b0; b_mask = 4'd0; b_in = 4'd0;

      // Reset state
      tick();
      chk4("rst_addr", {2'b00, a_addr}, 4'd0);
      chk4("rst_word", a_word, 4'd0);
      chk1("rst_valid", a_valid, 1'b0);
      chk1("rst_busy", a_busy, 1'b0);
      chk1("rst_ovr", a_ovr, 1'b0);
      chk1("rst_b_busy", b_busy, 1'b0);
      reset = 1'b0;
      tick();
      chk1("post_rst_busy", a_busy, 1'b0);

      // Full scan, mask 1111, inputs 1101; mask change after accept must be ignored
      a_in = 4'b1101; a_mask = 4'b1111; a_start = 1'b1;
      tick();
      a_start = 1'b0; a_mask = 4'b0000;
      chk4("full_e0_addr", {2'b00, a_addr}, 4'd0);
      chk1("full_e0_busy", a_busy, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk4("full_addr", {2'b00, a_addr}, (i < 8) ? 4'(i / 2) : 4'd3);
         chk1("full_valid", a_valid, (i == 8));
      end
      chk4("full_word", a_word, 4'b1101);
      chk1("full_busy_pend", a_busy, 1'b1);
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
      chk1("full_acc_valid", a_valid, 1'b0);
      chk1("full_acc_busy", a_busy, 1'b0);
      chk4("full_acc_word", a_word, 4'b1101);

      // Sparse mask 0101, all inputs high: masked channels read as 0
      a_in = 4'b1111; a_mask = 4'b0101; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      chk4("sparse_e0_addr", {2'b00, a_addr}, 4'd0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk4("sparse_addr", {2'b00, a_addr}, (i < 2) ? 4'd0 : 4'd2);
         chk1("sparse_valid", a_valid, (i == 4));
      end
      chk4("sparse_word", a_word, 4'b0101);

      // Backpressure: start ignored while a word is pending
      a_start = 1'b1; a_mask = 4'b1111;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk4("bp_word", a_word, 4'b0101);
         chk1("bp_valid", a_valid, 1'b1);
         chk4("bp_addr", {2'b00, a_addr}, 4'd2);
      end
      a_start = 1'b0; a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
      chk1("bp_acc_valid", a_valid, 1'b0);
      chk1("bp_acc_busy", a_busy, 1'b0);
      a_start = 1'b1; a_mask = 4'b1000;
      tick();
      a_start = 1'b0;
      chk1("restart_busy", a_busy, 1'b1);
      chk4("restart_addr", {2'b00, a_addr}, 4'd3);

      // Stop mid-frame: idle next edge, no word produced
      a_stop = 1'b1;
      tick();
      a_stop = 1'b0;
      chk1("stop_busy", a_busy, 1'b0);
      chk4("stop_addr", {2'b00, a_addr}, 4'd3);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk1("stop_no_word", a_valid, 1'b0);
      end

      // Empty mask and stop+start collision are both ignored
      a_start = 1'b1; a_mask = 4'b0000;
      tick();
      chk1("mask0_busy", a_busy, 1'b0);
      chk1("mask0_valid", a_valid, 1'b0);
      chk4("mask0_addr", {2'b00, a_addr}, 4'd3);
      a_mask = 4'b0001; a_stop = 1'b1;
      tick();
      a_start = 1'b0; a_stop = 1'b0;
      chk1("stopwins_busy", a_busy, 1'b0);
      chk4("stopwins_addr", {2'b00, a_addr}, 4'd3);

      // Continuous, ready low: second frame at edge 4 overruns
      b_in = 4'b0001; b_mask = 4'b0011; b_start = 1'b1;
      tick();
      b_start = 1'b0;
      chk4("c1_e0_addr", {2'b00, b_addr}, 4'd0);
      tick();
      chk4("c1_e1_addr", {2'b00, b_addr}, 4'd1);
      chk1("c1_e1_valid", b_valid, 1'b0);
      tick();
      chk1("c1_e2_valid", b_valid, 1'b1);
      chk4("c1_e2_word", b_word, 4'b0001);
      chk4("c1_e2_addr", {2'b00, b_addr}, 4'd0);
      chk1("c1_e2_ovr", b_ovr, 1'b0);
      b_in = 4'b0010;
      tick();
      chk4("c1_e3_word", b_word, 4'b0001);
      chk4("c1_e3_addr", {2'b00, b_addr}, 4'd1);
      tick();
      chk4("c1_e4_word", b_word, 4'b0010);
      chk1("c1_e4_valid", b_valid, 1'b1);
      chk1("c1_e4_ovr", b_ovr, 1'b1);
      b_stop = 1'b1;
      tick();
      b_stop = 1'b0;
      chk1("c1_stop_valid", b_valid, 1'b1);
      chk4("c1_stop_word", b_word, 4'b0010);
      chk1("c1_stop_busy", b_busy, 1'b1);
      chk4("c1_stop_addr", {2'b00, b_addr}, 4'd0);
      tick();
      chk1("c1_idle_valid", b_valid, 1'b1);
      chk4("c1_idle_addr", {2'b00, b_addr}, 4'd0);
      b_ready = 1'b1;
      tick();
      b_ready = 1'b0;
      chk1("c1_acc_valid", b_valid, 1'b0);
      chk1("c1_acc_busy", b_busy, 1'b0);
      chk1("c1_ovr_sticky", b_ovr, 1'b1);

      // Reset pulsed between edges mid-frame
      a_in = 4'b1111; a_mask = 4'b1111; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      tick();
      tick();
      chk4("mid_addr_pre", {2'b00, a_addr}, 4'd1);
      #2 reset = 1'b1;
      #1;
      chk4("mid_rst_addr", {2'b00, a_addr}, 4'd0);
      chk4("mid_rst_word", a_word, 4'd0);
      chk1("mid_rst_valid", a_valid, 1'b0);
      chk1("mid_rst_busy", a_busy, 1'b0);
      chk1("mid_rst_b_ovr", b_ovr, 1'b0);
      chk4("mid_rst_b_word", b_word, 4'd0);
      #2 reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk1("mid_no_word", a_valid, 1'b0);
         chk1("mid_idle_busy", a_busy, 1'b0);
      end

      // Continuous with ready high at edge 4: no overrun, valid held
      b_in = 4'b0011; b_mask = 4'b0011; b_start = 1'b1;
      tick();
      b_start = 1'b0;
      tick();
      tick();
      chk1("c2_e2_valid", b_valid, 1'b1);
      chk4("c2_e2_word", b_word, 4'b0011);
      b_in = 4'b0010;
      tick();
      chk4("c2_e3_word", b_word, 4'b0011);
      b_ready = 1'b1;
      tick();
      chk1("c2_e4_valid", b_valid, 1'b1);
      chk4("c2_e4_word", b_word, 4'b0010);
      chk1("c2_e4_ovr", b_ovr, 1'b0);
      b_stop = 1'b1;
      tick();
      b_stop = 1'b0; b_ready = 1'b0;
      chk1("c2_end_valid", b_valid, 1'b0);
      chk1("c2_end_busy", b_busy, 1'b0);
      chk1("c2_end_ovr", b_ovr, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream control stage for the 4:1 gate-level multiplexer: drives its address0/address1 select lines, waits a programmable settle time for gate delays, then samples the single-bit mux output.
- Walks all channels enabled in a mask, assembles the samples into a 4-bit word, and hands the word downstream on a valid/ready handshake.
- Supports single-shot and continuous scanning.

Parameters:
- SETTLE_CYCLES, 2: clock edges from an address change to the sample of mux_out. Legal values are 1 and above.
- CONTINUOUS, 0: 0 = one frame per start; 1 = rescan back-to-back until stop.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  begin a scan; sampled in IDLE only.
- stop  input  1  abort scanning; returns to IDLE at the next edge.
- chan_mask  input  4  bit i enables channel i; latched on accepted start.
- mux_out  input  1  output of the downstream-selected mux.
- address0  output  1  mux select bit 0, registered.
- address1  output  1  mux select bit 1, registered.
- word  output  4  assembled frame; bit i = sample of channel i, 0 if masked.
- word_valid  output  1  word holds an unaccepted frame.
- word_ready  input  1  consumer accepts word at an edge where valid&ready.
- busy  output  1  (state != IDLE) | word_valid.
- overrun  output  1  sticky: a frame overwrote an unaccepted word.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: address0=0, address1=0, word=0, word_valid=0, overrun=0, busy=0, state=IDLE, capture register=0, settle counter=0.
- States: IDLE and SETTLE.
- IDLE:
  - Start is accepted when start=1, stop=0, busy=0 and chan_mask!=0.
  - On acceptance: latch mask_q=chan_mask and clear the capture register.
  - Set ch = lowest set bit of mask_q, drive address={address1,address0}=ch, load counter=SETTLE_CYCLES, go to SETTLE.
  - start with chan_mask=0, or while busy, is ignored with no side effects.
  - stop and start at the same edge: stop wins.
- SETTLE:
  - The counter decrements every edge.
  - At the edge where counter==1, sample: capture[ch]=mux_out.
  - If a higher enabled channel exists in mask_q, move ch and the address to it and reload the counter.
  - Otherwise the frame is complete.
- Frame complete:
  - word = capture with the final bit merged, set word_valid=1, all at the same edge.
  - CONTINUOUS=0: go to IDLE, address holds its last value.
  - CONTINUOUS=1: clear capture, reload ch = lowest enabled channel, drive that address, reload counter, stay in SETTLE.
- Latency: k enabled channels → the last sample and word_valid rise exactly k*SETTLE_CYCLES edges after the start-accept edge. Each address value is held exactly SETTLE_CYCLES cycles.
- Handshake:
  - word and word_valid are stable while valid=1 and ready=0.
  - At an edge with valid&ready, valid drops unless a new frame completes at that same edge. In that case the new word loads, valid stays 1, and there is no overrun.
  - Frame complete while valid=1 and ready=0: word is overwritten and overrun=1. overrun is cleared only by reset.
- stop:
  - In SETTLE, go to IDLE at the next edge and discard the partial capture.
  - word and word_valid are untouched; a pending word still completes its handshake.
  - The address holds.
- Latching: chan_mask changes after start acceptance have no effect until the next start.
- Address updates: address0 and address1 change only at sample/load edges; they never change in IDLE.
- Reset mid-frame: all outputs return to their reset values asynchronously, with no word emitted.

Test Plan:
- Full scan: SETTLE_CYCLES=2, mask=1111, in0..in3=1,0,1,1 → address sequence 0,1,2,3 (2 cycles each); word=4'b1101; word_valid rises 8 edges after start; busy drops after the ready edge.
- Sparse mask: mask=0101, in0=1, in2=1 → addresses 0 then 2 only; word=4'b0101; valid after 4 edges. Mask=0000 with start → busy, valid and address unchanged.
- Backpressure: hold ready=0 for 10 cycles after valid → word stable and start ignored; raise ready → valid=0, busy=0, and a new start is accepted the next cycle.
- Continuous: CONTINUOUS=1, SETTLE_CYCLES=1, mask=0011, ready=0 → second frame at edge 4 sets overrun=1 with the word updated. Repeat with ready=1 at edge 4 → no overrun, valid stays 1.
- Stop: stop asserted mid-frame → IDLE next edge, no new word, pending valid preserved.
- Reset mid-frame: reset pulsed between edges during SETTLE → all outputs 0 immediately without a clock edge; no word afterward.
